// File: rtl/cdc_gray_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdc_gray_pkg
// Description : Gray/binary pointer conversion shared by both FIFO halves.
// Revision    : 1.0 - initial release
// ============================================================================
package cdc_gray_pkg;

    localparam int c_ptr_max_w = 32;

    // Callers zero-extend narrower pointers into this word and cast the result back
    typedef logic [c_ptr_max_w-1:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin[c_ptr_max_w-1] = gray[c_ptr_max_w-1];
        for (int i = c_ptr_max_w - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_sync_stage.sv
`default_nettype none
// ============================================================================
// Module      : cdc_sync_stage
// Description : Multi-flop synchronizer chain for an asynchronous bus.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_sync_stage #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    if (STAGES < 1) begin : g_check_stages
        $error("cdc_sync_stage: STAGES must be at least 1");
    end

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/axi_cdc_src_chan.sv
`default_nettype none
// ============================================================================
// Module      : axi_cdc_src_chan
// Description : Source (write) half of a gray-pointer CDC FIFO channel.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_cdc_src_chan
    import cdc_gray_pkg::*;
#(
    parameter int  LogDepth   = 1,
    parameter int  SyncStages = 2,
    parameter type T          = logic
) (
    input  logic              src_clk_i,
    input  logic              src_rst_i,
    input  T                  src_data_i,
    input  logic              src_valid_i,
    output logic              src_ready_o,
    output logic [LogDepth:0] src_fill_o,
    output T                  async_data_o [2**LogDepth],
    output logic [LogDepth:0] async_wptr_o,
    input  logic [LogDepth:0] async_rptr_i
);

    localparam int c_ptr_w = LogDepth + 1;
    localparam int c_depth = 2**LogDepth;
    localparam logic [LogDepth:0] c_full_level = {1'b1, {LogDepth{1'b0}}};
    localparam logic [LogDepth:0] c_ptr_one    = {{LogDepth{1'b0}}, 1'b1};

    if (LogDepth < 1) begin : g_check_depth
        $error("axi_cdc_src_chan: LogDepth must be at least 1");
    end
    if (c_ptr_w > c_ptr_max_w) begin : g_check_ptr_width
        $error("axi_cdc_src_chan: LogDepth too large for pointer helpers");
    end
    if (SyncStages < 2) begin : g_check_sync
        $error("axi_cdc_src_chan: SyncStages must be at least 2");
    end

    logic [LogDepth:0] r_wptr_bin;
    logic [LogDepth:0] r_wptr_gray;
    logic [LogDepth:0] w_wptr_next;
    logic [LogDepth:0] w_wptr_next_gray;
    logic [LogDepth:0] w_rptr_sync;
    logic [LogDepth:0] w_rptr_bin;
    logic [LogDepth:0] w_fill;
    logic              w_full;
    logic              w_ready;
    logic              w_push;
    T                  r_data [c_depth];

    cdc_sync_stage #(
        .WIDTH  (c_ptr_w),
        .STAGES (SyncStages)
    ) u_rptr_sync (
        .clk    (src_clk_i),
        .rst    (src_rst_i),
        .i_data (async_rptr_i),
        .o_data (w_rptr_sync)
    );

    assign w_rptr_bin       = c_ptr_w'(gray2bin(ptr_word_t'(w_rptr_sync)));
    assign w_wptr_next      = r_wptr_bin + c_ptr_one;
    assign w_wptr_next_gray = c_ptr_w'(bin2gray(ptr_word_t'(w_wptr_next)));

    // Modular subtraction keeps the level correct across pointer wrap
    assign w_fill  = r_wptr_bin - w_rptr_bin;
    assign w_full  = (w_fill == c_full_level);
    assign w_ready = !w_full && !src_rst_i;
    assign w_push  = src_valid_i && w_ready;

    always_ff @(posedge src_clk_i) begin
        if (src_rst_i) begin
            r_wptr_bin  <= '0;
            r_wptr_gray <= '0;
            for (int i = 0; i < c_depth; i++) begin
                r_data[i] <= '0;
            end
        end else if (w_push) begin
            // Slot and gray pointer move together so the reader never sees a pointer ahead of its data
            r_data[r_wptr_bin[LogDepth-1:0]] <= src_data_i;
            r_wptr_bin  <= w_wptr_next;
            r_wptr_gray <= w_wptr_next_gray;
        end
    end

    assign src_ready_o  = w_ready;
    assign src_fill_o   = w_fill;
    assign async_wptr_o = r_wptr_gray;
    assign async_data_o = r_data;

endmodule
`default_nettype wire

// File: tb/tb_axi_cdc_src_chan.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_cdc_src_chan
// Description : Self-checking bench for the CDC FIFO source half.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_cdc_src_chan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Depth-2 instance
    logic       rst1 = 1'b1;
    logic [7:0] data1 = 8'h55;
    logic       valid1 = 1'b1;
    logic       ready1;
    logic [1:0] fill1;
    logic [7:0] adata1 [2];
    logic [1:0] wptr1;
    logic [1:0] rptr1 = 2'b00;

    // Depth-4 instance
    logic       rst2 = 1'b1;
    logic [7:0] data2 = 8'h00;
    logic       valid2 = 1'b0;
    logic       ready2;
    logic [2:0] fill2;
    logic [7:0] adata2 [4];
    logic [2:0] wptr2;
    logic [2:0] rptr2 = 3'b000;

    axi_cdc_src_chan #(.LogDepth(1), .SyncStages(2), .T(logic [7:0])) dut1 (
        .src_clk_i(clk), .src_rst_i(rst1), .src_data_i(data1), .src_valid_i(valid1),
        .src_ready_o(ready1), .src_fill_o(fill1), .async_data_o(adata1),
        .async_wptr_o(wptr1), .async_rptr_i(rptr1)
    );

    axi_cdc_src_chan #(.LogDepth(2), .SyncStages(2), .T(logic [7:0])) dut2 (
        .src_clk_i(clk), .src_rst_i(rst2), .src_data_i(data2), .src_valid_i(valid2),
        .src_ready_o(ready2), .src_fill_o(fill2), .async_data_o(adata2),
        .async_wptr_o(wptr2), .async_rptr_i(rptr2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] gray3(input int n);
        int m;
        m = n % 8;
        return 3'(m ^ (m >> 1));
    endfunction

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic [1:0] rptr;
        logic       exp_ready;
        logic [1:0] exp_fill;
        logic [1:0] exp_wptr;
        logic [7:0] exp_s0;
        logic [7:0] exp_s1;
    } vec_t;

    vec_t vecs [6];

    // Behavioural model for the randomized phase on the depth-4 instance
    logic [7:0] exp_q [$];
    int         wr_cnt, rd_cnt, rd_h0, rd_h1, exp_fill, rd_prob;
    logic       exp_ready;
    logic [2:0] prev_wptr;

    initial begin
        vecs[0] = '{1'b1, 8'h0A, 2'b00, 1'b1, 2'd1, 2'b01, 8'h0A, 8'h00};
        vecs[1] = '{1'b1, 8'h0B, 2'b00, 1'b0, 2'd2, 2'b11, 8'h0A, 8'h0B};
        vecs[2] = '{1'b1, 8'h0C, 2'b00, 1'b0, 2'd2, 2'b11, 8'h0A, 8'h0B};
        vecs[3] = '{1'b1, 8'h0C, 2'b01, 1'b0, 2'd2, 2'b11, 8'h0A, 8'h0B};
        vecs[4] = '{1'b1, 8'h0C, 2'b01, 1'b1, 2'd1, 2'b11, 8'h0A, 8'h0B};
        vecs[5] = '{1'b1, 8'h0C, 2'b01, 1'b0, 2'd2, 2'b10, 8'h0C, 8'h0B};

        // Reset held two edges with valid asserted: nothing may be written
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", ready1, 1'b0);
        check("rst_wptr", wptr1, 2'b00);
        check("rst_fill", fill1, 2'd0);
        rst1 = 1'b0;
        valid1 = 1'b0;
        @(negedge clk);
        check("post_rst_ready", ready1, 1'b1);
        check("post_rst_wptr", wptr1, 2'b00);
        check("post_rst_fill", fill1, 2'd0);
        check("post_rst_s0", adata1[0], 8'h00);
        check("post_rst_s1", adata1[1], 8'h00);

        // Fill, stall while full, then release through the synchronizer
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                for (int k = 0; k < 10; k++) begin
                    valid1 = 1'b1; data1 = 8'h0C; rptr1 = 2'b00;
                    @(negedge clk);
                    check("hold_wptr", wptr1, 2'b11);
                    check("hold_fill", fill1, 2'd2);
                    check("hold_ready", ready1, 1'b0);
                end
            end
            valid1 = vecs[i].valid;
            data1  = vecs[i].data;
            rptr1  = vecs[i].rptr;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), ready1, vecs[i].exp_ready);
            check($sformatf("vec%0d_fill", i), fill1, vecs[i].exp_fill);
            check($sformatf("vec%0d_wptr", i), wptr1, vecs[i].exp_wptr);
            check($sformatf("vec%0d_s0", i), adata1[0], vecs[i].exp_s0);
            check($sformatf("vec%0d_s1", i), adata1[1], vecs[i].exp_s1);
        end
        valid1 = 1'b0;

        // Depth-4: push two, then push on the edge where a release lands
        rst2 = 1'b0;
        valid2 = 1'b1; data2 = 8'h11;
        @(negedge clk);
        data2 = 8'h22;
        @(negedge clk);
        valid2 = 1'b0;
        check("sim_pre_fill", fill2, 3'd2);
        check("sim_pre_wptr", wptr2, 3'b011);
        rptr2 = 3'b001;
        @(negedge clk);
        check("sim_mid_fill", fill2, 3'd2);
        valid2 = 1'b1; data2 = 8'h33;
        @(negedge clk);
        check("sim_fill", fill2, 3'd2);
        check("sim_ready", ready2, 1'b1);
        check("sim_wptr", wptr2, 3'b010);
        check("sim_slot2", adata2[2], 8'h33);
        data2 = 8'h44;
        @(negedge clk);
        data2 = 8'h55;
        @(negedge clk);
        valid2 = 1'b0;
        check("full4_fill", fill2, 3'd4);
        check("full4_ready", ready2, 1'b0);

        // Single-cycle reset pulse discards everything
        rst2 = 1'b1; rptr2 = 3'b000;
        @(negedge clk);
        check("midrst_ready_low", ready2, 1'b0);
        rst2 = 1'b0;
        #1;
        check("midrst_wptr", wptr2, 3'b000);
        check("midrst_fill", fill2, 3'd0);
        check("midrst_ready", ready2, 1'b1);
        for (int s = 0; s < 4; s++) check($sformatf("midrst_slot%0d", s), adata2[s], 8'h00);
        @(negedge clk);

        // Randomized traffic with an echoing reader; slow reader first so full is exercised
        wr_cnt = 0; rd_cnt = 0; rd_h0 = 0; rd_h1 = 0;
        prev_wptr = 3'b000;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rd_prob = (cyc < 200) ? 1 : 3;
            exp_fill  = wr_cnt - rd_h1;
            exp_ready = (exp_fill < 4);
            check("rnd_fill", fill2, exp_fill);
            check("rnd_ready", ready2, exp_ready);
            check("rnd_wptr", wptr2, gray3(wr_cnt));
            check("rnd_wptr_step", $countones(prev_wptr ^ wptr2) <= 1, 1'b1);
            prev_wptr = wptr2;
            if (rd_cnt < wr_cnt && $urandom_range(0, 3) < rd_prob) begin
                check("rnd_rdata", adata2[rd_cnt % 4], exp_q.pop_front());
                rd_cnt++;
            end
            rptr2  = gray3(rd_cnt);
            valid2 = ($urandom_range(0, 3) != 0);
            data2  = 8'($urandom);
            @(posedge clk);
            if (valid2 && exp_ready) begin
                exp_q.push_back(data2);
                wr_cnt++;
            end
            rd_h1 = rd_h0;
            rd_h0 = rd_cnt;
            @(negedge clk);
        end
        check("rnd_wrapped", wr_cnt >= 20, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
